cmutex_merge_rr_q: RTL and testbench
====================================

# cmutex_merge_rr_q

Clocked, parametrised N-channel mutex merge with a built-in output queue. It keeps the drive/free pulse handshake of the two-channel asynchronous merge and generalises it in four ways: channel count and data width are parameters, arbitration is selectable (round-robin or fixed priority), and queue depth is a parameter. Because the queue is internal, the block no longer needs an external FIFO behind it. It sits between several request producers (e.g. miss/writeback sources) and a single downstream consumer in the cache subsystem.

## Interface
Parameters:
- NCH, 2, number of input channels (2..8)
- WIDTH, 35, data width per channel
- DEPTH, 4, queue entries (power of 2, ≥2)
- RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority, lowest channel index wins

Ports:
- clk  in  1  single clock, rising edge
- rstn  in  1  reset; asynchronous, active-low
- i_drive  in  NCH  per-channel one-cycle request pulse
- i_data  in  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]; producer holds it stable from i_drive until o_free
- o_free  out  NCH  per-channel one-cycle acknowledge pulse
- o_driveNext  out  1  one-cycle pulse: o_data valid
- o_data  out  WIDTH  queue head, held until i_freeNext
- i_freeNext  in  1  one-cycle pulse from consumer: head consumed
- o_count  out  $clog2(DEPTH+1)  current queue occupancy
- o_err  out  1  sticky protocol-error flag

## Operation
- pending[k] is set when i_drive[k] is sampled high. i_drive[k] while pending[k]=1 is a protocol error: set o_err and ignore the pulse.
- Grant: on each edge where count<DEPTH (registered count) and any pending bit is set, exactly one winner is chosen.
  - The winner's i_data slice is written at the tail, pending[winner] is cleared, and o_free[winner] is asserted for the following cycle.
- RR_MODE=1: the search starts at last+1 and wraps modulo NCH. last is updated to the winner. Reset value of last is NCH-1, so channel 0 wins first after reset.
- RR_MODE=0: the lowest pending index wins and last is unused.
- Full (count==DEPTH): no grant is made. Pending requests wait and nothing is lost. A pop in the same cycle does not enable a grant in that cycle.
- Output FSM, two states:
  - IDLE: if count>0, load o_data from the head, pulse o_driveNext, and go to WAIT.
  - WAIT: hold o_data. When i_freeNext is sampled, pop the head and return to IDLE.
  - i_freeNext in IDLE is ignored and sets o_err.
- Push and pop on the same edge leave count unchanged. Read and write pointers are log2(DEPTH) bits and wrap naturally.
- Output order is exactly grant order.

## Timing
- Reset (asynchronous assert): o_free=0, o_driveNext=0, o_data=0, o_count=0, o_err=0. Also clears pending, empties the queue, sets FSM to IDLE and last=NCH-1. Any queued or pending data is discarded.
- Deassertion is synchronised externally. The first functional edge follows.
- Latency when the queue is empty, with i_drive[k] high in cycle 0:
  - pending set at end of cycle 0
  - grant at end of cycle 1
  - o_free[k]=1 and o_count=1 in cycle 2
  - o_driveNext=1 with valid o_data in cycle 3
- An i_freeNext pulse in cycle n (n ≥ the o_driveNext cycle) pops the head at end of cycle n. The next o_driveNext is no earlier than cycle n+2.
- Throughput: at most one grant per cycle and one output item per two cycles.
- o_free pulses are exactly one cycle wide. Multiple channels never receive o_free in the same cycle.
- An i_drive[k] in the same cycle as o_free[k] is accepted, because pending is already clear.

## Test plan
- Single request: NCH=2, i_drive[0] with data 35'h1_2345_6789 in cycle 0 → o_free[0] in cycle 2, o_driveNext with o_data=35'h1_2345_6789 in cycle 3. After i_freeNext in cycle 5, o_count=0 in cycle 6.
- Round-robin fairness: NCH=4, RR_MODE=1, all four channels re-drive immediately after each o_free, consumer always frees → grant sequence 0,1,2,3,0,1,… with no channel skipped.
- Fixed priority: RR_MODE=0, channels 0 and 2 continuously pending → channel 0 always wins and channel 2 waits until channel 0 stops driving.
- Full queue: DEPTH=4, consumer never frees, 6 requests across channels → exactly 4 o_free pulses, o_count=4, and 2 remaining pending bits. Freeing one head yields exactly one further o_free.
- Protocol errors: a second i_drive[1] before o_free[1], and a separate i_freeNext while IDLE → o_err=1 and stays high, queue contents unchanged, no extra o_free.
- Reset mid-operation: assert rstn=0 with o_count=3 and FSM in WAIT → all outputs 0 immediately, and after release no o_driveNext until new i_drive.

Source files
------------

// File: rtl/cmutex_merge_rr_q.sv
// N-channel mutex merge with an internal output queue.
// Producers raise one-cycle i_drive pulses. Each request waits as a pending bit until
// it wins arbitration. The winner's data is pushed into the queue and the producer is
// acknowledged with a one-cycle o_free. The output side presents one queue entry at a
// time with a one-cycle o_driveNext, and pops that entry when i_freeNext arrives.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | nothing is presented; load the head when the queue is non-empty
//   ST_WAIT | o_data holds the head; wait for the consumer's i_freeNext
module cmutex_merge_rr_q #(
  parameter int NCH     = 2,
  parameter int WIDTH   = 35,
  parameter int DEPTH   = 4,
  parameter int RR_MODE = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NCH-1:0]             i_drive,
  input  logic [NCH*WIDTH-1:0]       i_data,
  output logic [NCH-1:0]             o_free,
  output logic                       o_driveNext,
  output logic [WIDTH-1:0]           o_data,
  input  logic                       i_freeNext,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(NCH);
  localparam logic [CW-1:0] FULL_C     = CW'(DEPTH);
  localparam logic [LW-1:0] LAST_RST_C = LW'(NCH - 1);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NCH-1:0]    r_pending;
  logic [LW-1:0]     r_last;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [NCH-1:0]    r_free;
  logic              r_drive_next;
  logic [WIDTH-1:0]  r_data;
  logic              r_err;

  logic              w_hi_found;
  logic [LW-1:0]     w_hi_idx;
  logic              w_lo_found;
  logic [LW-1:0]     w_lo_idx;
  logic [LW-1:0]     w_winner;
  logic              w_grant;
  logic [NCH-1:0]    w_grant_vec;
  logic [WIDTH-1:0]  w_win_data;
  logic              w_load;
  logic              w_pop;
  logic              w_free_err;
  logic              w_drive_err;

  // Winner search: lowest pending index overall, and lowest pending index above last.
  // Round-robin takes the one above last when it exists, otherwise wraps to the lowest.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (r_pending[k]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = LW'(k);
        if (LW'(k) > r_last) begin
          w_hi_found = 1'b1;
          w_hi_idx   = LW'(k);
        end
      end
    end
    w_winner = ((RR_MODE != 0) && w_hi_found) ? w_hi_idx : w_lo_idx;
    // Registered count only: a pop on this edge does not open a slot until the next one.
    w_grant  = w_lo_found && (r_count < FULL_C);
  end

  // Decode the grant to a one-hot vector and select the winner's data slice.
  always_comb begin
    w_grant_vec = '0;
    w_win_data  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (w_winner == LW'(k)) begin
        w_grant_vec[k] = w_grant;
        w_win_data     = i_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // A request on a channel that is still pending is dropped and flagged.
  assign w_drive_err = |(i_drive & r_pending);

  // Output FSM next-state and control.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_pop       = 1'b0;
    w_free_err  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_freeNext) begin
          w_free_err = 1'b1;
        end
        if (r_count != '0) begin
          w_load      = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_freeNext) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pending bits, arbitration pointer and acknowledge pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pending <= '0;
      r_last    <= LAST_RST_C;
      r_free    <= '0;
    end else begin
      r_pending <= (r_pending & ~w_grant_vec) | (i_drive & ~r_pending);
      r_free    <= w_grant_vec;
      if (w_grant && (RR_MODE != 0)) begin
        r_last <= w_winner;
      end
    end
  end

  // Queue storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_mem[r_wptr] <= w_win_data;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_grant) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_grant, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output presentation and the sticky protocol-error flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_drive_next <= 1'b0;
      r_data       <= '0;
      r_err        <= 1'b0;
    end else begin
      r_drive_next <= w_load;
      if (w_load) begin
        r_data <= r_mem[r_rptr];
      end
      r_err <= r_err | w_drive_err | w_free_err;
    end
  end

  assign o_free      = r_free;
  assign o_driveNext = r_drive_next;
  assign o_data      = r_data;
  assign o_count     = r_count;
  assign o_err       = r_err;

endmodule

// File: tb/tb_cmutex_merge_rr_q.sv
// Directed bench for cmutex_merge_rr_q: one round-robin and one fixed-priority
// instance, 4 channels, 35-bit data, 4-entry queue.
module tb_cmutex_merge_rr_q;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;

  logic [3:0]   rr_drive, fp_drive;
  logic [139:0] rr_data, fp_data;
  logic [3:0]   rr_free, fp_free;
  logic         rr_dn, fp_dn;
  logic [34:0]  rr_odata, fp_odata;
  logic         rr_fn, fp_fn;
  logic [2:0]   rr_count, fp_count;
  logic         rr_err, fp_err;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [34:0]  chd [4];

  always #5 clk = ~clk;

  cmutex_merge_rr_q #(.NCH(4), .WIDTH(35), .DEPTH(4), .RR_MODE(1)) u_rr (
    .clk(clk), .rstn(rstn), .i_drive(rr_drive), .i_data(rr_data), .o_free(rr_free),
    .o_driveNext(rr_dn), .o_data(rr_odata), .i_freeNext(rr_fn), .o_count(rr_count),
    .o_err(rr_err)
  );

  cmutex_merge_rr_q #(.NCH(4), .WIDTH(35), .DEPTH(4), .RR_MODE(0)) u_fp (
    .clk(clk), .rstn(rstn), .i_drive(fp_drive), .i_data(fp_data), .o_free(fp_free),
    .o_driveNext(fp_dn), .o_data(fp_odata), .i_freeNext(fp_fn), .o_count(fp_count),
    .o_err(fp_err)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] free_of(input int which);
    return (which != 0) ? fp_free : rr_free;
  endfunction

  function automatic logic dn_of(input int which);
    return (which != 0) ? fp_dn : rr_dn;
  endfunction

  function automatic logic [34:0] odata_of(input int which);
    return (which != 0) ? fp_odata : rr_odata;
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    rr_drive = '0; fp_drive = '0; rr_fn = 1'b0; fp_fn = 1'b0;
    cyc();
    cyc();
    rstn = 1'b1;
    cyc();
  endtask

  task automatic wait_free(input int which, input string tag, input logic [3:0] exp);
    int n;
    n = 1;
    cyc();
    while (free_of(which) == 4'b0 && n < 20) begin
      cyc();
      n++;
    end
    chk(tag, free_of(which), exp);
  endtask

  task automatic wait_dn(input int which, input string tag, input logic [34:0] exp);
    int n;
    n = 1;
    cyc();
    while (!dn_of(which) && n < 20) begin
      cyc();
      n++;
    end
    chk({tag, "_dn"}, dn_of(which), 1'b1);
    chk({tag, "_data"}, odata_of(which), exp);
  endtask

  task automatic count_free(input int which, input int ncyc, output int np, output logic [3:0] m);
    np = 0;
    m  = '0;
    for (int i = 0; i < ncyc; i++) begin
      cyc();
      if (free_of(which) != 4'b0) begin
        np++;
        m = m | free_of(which);
      end
    end
  endtask

  initial begin
    int          g, d, n, np;
    logic [3:0]  m;

    chd[0] = 35'h1_2345_6789;
    chd[1] = 35'h0_ABCD_0001;
    chd[2] = 35'h7_0000_0002;
    chd[3] = 35'h2_5A5A_0003;
    for (int k = 0; k < 4; k++) begin
      rr_data[k*35 +: 35] = chd[k];
      fp_data[k*35 +: 35] = chd[k];
    end
    rr_drive = '0; fp_drive = '0; rr_fn = 1'b0; fp_fn = 1'b0;

    // reset state
    cyc();
    cyc();
    chk("rst_free", rr_free, 4'b0);
    chk("rst_dn", rr_dn, 1'b0);
    chk("rst_data", rr_odata, 35'h0);
    chk("rst_count", rr_count, 3'd0);
    chk("rst_err", rr_err, 1'b0);
    rstn = 1'b1;
    cyc();

    // single request, exact latency
    rr_drive = 4'b0001;
    cyc();
    rr_drive = 4'b0;
    chk("single_c1_free", rr_free, 4'b0);
    cyc();
    chk("single_c2_free", rr_free, 4'b0001);
    chk("single_c2_count", rr_count, 3'd1);
    chk("single_c2_dn", rr_dn, 1'b0);
    cyc();
    chk("single_c3_dn", rr_dn, 1'b1);
    chk("single_c3_data", rr_odata, chd[0]);
    chk("single_c3_free", rr_free, 4'b0);
    cyc();
    chk("single_c4_dn", rr_dn, 1'b0);
    cyc();
    rr_fn = 1'b1;
    cyc();
    rr_fn = 1'b0;
    chk("single_c6_count", rr_count, 3'd0);
    chk("single_err", rr_err, 1'b0);

    // round-robin fairness with continuous re-drive and an always-ready consumer
    do_reset();
    rr_drive = 4'hF;
    cyc();
    rr_drive = 4'b0;
    g = 0; d = 0; n = 0;
    while (g < 8 && n < 100) begin
      cyc();
      n++;
      rr_drive = rr_free;
      rr_fn    = rr_dn;
      if (rr_free != 4'b0) begin
        chk("rr_grant", rr_free, 64'd1 << (g % 4));
        g++;
      end
      if (rr_dn) begin
        chk("rr_order", rr_odata, chd[d % 4]);
        d++;
      end
    end
    rr_drive = 4'b0;
    rr_fn    = 1'b0;
    chk("rr_grant_total", g, 8);
    chk("rr_err", rr_err, 1'b0);

    // fixed priority under backpressure: channels 0 and 2 compete for freed slots
    do_reset();
    fp_drive = 4'hF;
    cyc();
    fp_drive = 4'b0;
    wait_free(1, "fp_fill0", 4'b0001);
    wait_free(1, "fp_fill1", 4'b0010);
    wait_free(1, "fp_fill2", 4'b0100);
    wait_free(1, "fp_fill3", 4'b1000);
    chk("fp_full_count", fp_count, 3'd4);
    fp_drive = 4'b0101;
    cyc();
    fp_drive = 4'b0;
    count_free(1, 6, np, m);
    chk("fp_full_hold", np, 0);
    chk("fp_full_count2", fp_count, 3'd4);
    fp_fn = 1'b1;
    cyc();
    fp_fn = 1'b0;
    chk("fp_pop_no_same_grant", fp_free, 4'b0);
    chk("fp_pop_count", fp_count, 3'd3);
    cyc();
    chk("fp_pri0_a", fp_free, 4'b0001);
    chk("fp_head2_dn", fp_dn, 1'b1);
    chk("fp_head2_data", fp_odata, chd[1]);
    fp_drive = 4'b0001;
    cyc();
    fp_drive = 4'b0;
    fp_fn = 1'b1;
    cyc();
    fp_fn = 1'b0;
    wait_free(1, "fp_pri0_b", 4'b0001);
    fp_fn = 1'b1;
    cyc();
    fp_fn = 1'b0;
    wait_free(1, "fp_ch2_after", 4'b0100);
    chk("fp_err", fp_err, 1'b0);

    // full queue: 6 requests, consumer idle, then one pop per extra grant
    do_reset();
    rr_drive = 4'hF;
    cyc();
    rr_drive = 4'b0;
    count_free(0, 8, np, m);
    chk("full_pulses", np, 4);
    chk("full_mask", m, 4'hF);
    chk("full_count", rr_count, 3'd4);
    rr_drive = 4'b0011;
    cyc();
    rr_drive = 4'b0;
    count_free(0, 8, np, m);
    chk("full_no_grant", np, 0);
    chk("full_count2", rr_count, 3'd4);
    rr_fn = 1'b1;
    cyc();
    rr_fn = 1'b0;
    count_free(0, 8, np, m);
    chk("full_pop1_pulses", np, 1);
    chk("full_pop1_mask", m, 4'b0001);
    chk("full_pop1_count", rr_count, 3'd4);
    rr_fn = 1'b1;
    cyc();
    rr_fn = 1'b0;
    count_free(0, 8, np, m);
    chk("full_pop2_pulses", np, 1);
    chk("full_pop2_mask", m, 4'b0010);
    chk("full_err", rr_err, 1'b0);

    // protocol error: second drive on channel 1 while still pending
    do_reset();
    rr_drive = 4'b0010;
    cyc();
    cyc();
    rr_drive = 4'b0;
    chk("proto_free", rr_free, 4'b0010);
    chk("proto_err_set", rr_err, 1'b1);
    count_free(0, 8, np, m);
    chk("proto_no_extra_free", np, 0);
    chk("proto_err_sticky", rr_err, 1'b1);
    chk("proto_count", rr_count, 3'd1);
    chk("proto_data", rr_odata, chd[1]);

    // protocol error: i_freeNext while IDLE with an empty queue
    do_reset();
    chk("proto2_err_clear", rr_err, 1'b0);
    rr_fn = 1'b1;
    cyc();
    rr_fn = 1'b0;
    cyc();
    chk("proto2_err_set", rr_err, 1'b1);
    chk("proto2_count", rr_count, 3'd0);
    chk("proto2_dn", rr_dn, 1'b0);
    rr_drive = 4'b1000;
    cyc();
    rr_drive = 4'b0;
    wait_dn(0, "proto2_queue", chd[3]);
    chk("proto2_count1", rr_count, 3'd1);
    chk("proto2_err_sticky", rr_err, 1'b1);

    // reset mid-operation with three entries queued and the FSM waiting
    do_reset();
    rr_drive = 4'b0111;
    cyc();
    rr_drive = 4'b0;
    repeat (4) cyc();
    chk("midrst_pre_count", rr_count, 3'd3);
    chk("midrst_pre_data", rr_odata, chd[0]);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_free", rr_free, 4'b0);
    chk("midrst_dn", rr_dn, 1'b0);
    chk("midrst_data", rr_odata, 35'h0);
    chk("midrst_count", rr_count, 3'd0);
    chk("midrst_err", rr_err, 1'b0);
    cyc();
    cyc();
    rstn = 1'b1;
    np = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (rr_dn) np++;
    end
    chk("midrst_no_dn", np, 0);
    chk("midrst_count_after", rr_count, 3'd0);
    rr_drive = 4'b0100;
    cyc();
    rr_drive = 4'b0;
    wait_dn(0, "midrst_new", chd[2]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
